// File: rtl/dec_scan_pkg.sv
// rtl/dec_scan_pkg.sv - shared constants and state type for the decoder scan sequencer
package dec_scan_pkg;

  localparam int SLOT_W = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_BLANK = S_BLANK,
    ST_DRIVE = S_DRIVE
  } state_t;

endpackage

// File: rtl/dec_scan_ctrl_if.sv
// rtl/dec_scan_ctrl_if.sv - control and decoder-drive bundle of the scan sequencer
interface dec_scan_ctrl_if;
  import dec_scan_pkg::*;

  logic              start;
  logic              stop;
  logic              mode;
  logic [SLOT_W-1:0] sel;
  logic              sel_en;
  logic              busy;
  logic              slot_tick;
  logic              done;

  modport master (
    output start, stop, mode,
    input  sel, sel_en, busy, slot_tick, done
  );

  modport slave (
    input  start, stop, mode,
    output sel, sel_en, busy, slot_tick, done
  );

endinterface

// File: rtl/dec_scan_timer.sv
// rtl/dec_scan_timer.sv - loadable down-counter pacing blank and dwell periods
module dec_scan_timer #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dec_scan_ctrl.sv
// rtl/dec_scan_ctrl.sv - slot scan sequencer driving a 4-to-16 decoder index and enable
module dec_scan_ctrl
  import dec_scan_pkg::*;
#(
  parameter int N_SLOTS = 16,
  parameter int DWELL   = 1000,
  parameter int BLANK   = 2,
  parameter int CNT_W   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  dec_scan_ctrl_if.slave   bus
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_SLOTS - 1);
  localparam logic [CNT_W-1:0]  DWELL_LD  = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0]  BLANK_LD  = (BLANK > 0) ? CNT_W'(BLANK - 1) : '0;

  state_t            state, state_nx;
  logic [SLOT_W-1:0] sel, sel_nx;
  logic              sel_en, sel_en_nx;
  logic              busy, busy_nx;
  logic              slot_tick, slot_tick_nx;
  logic              done, done_nx;
  logic              mode_q, mode_nx;
  logic              t_load, t_en, t_zero;
  logic [CNT_W-1:0]  t_val;

  dec_scan_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .zero     (t_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sel       <= '0;
      sel_en    <= 1'b0;
      busy      <= 1'b0;
      slot_tick <= 1'b0;
      done      <= 1'b0;
      mode_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      sel       <= sel_nx;
      sel_en    <= sel_en_nx;
      busy      <= busy_nx;
      slot_tick <= slot_tick_nx;
      done      <= done_nx;
      mode_q    <= mode_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    sel_nx       = sel;
    sel_en_nx    = 1'b0;
    slot_tick_nx = 1'b0;
    done_nx      = 1'b0;
    mode_nx      = mode_q;
    t_load       = 1'b0;
    t_val        = '0;
    t_en         = 1'b0;

    if (bus.stop) begin
      state_nx = ST_IDLE;
      sel_nx   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            mode_nx = bus.mode;
            sel_nx  = '0;
            t_load  = 1'b1;
            if (BLANK > 0) begin
              state_nx = ST_BLANK;
              t_val    = BLANK_LD;
            end else begin
              state_nx     = ST_DRIVE;
              t_val        = DWELL_LD;
              sel_en_nx    = 1'b1;
              slot_tick_nx = 1'b1;
            end
          end
        end
        ST_BLANK: begin
          t_en = 1'b1;
          if (t_zero) begin
            state_nx     = ST_DRIVE;
            t_load       = 1'b1;
            t_val        = DWELL_LD;
            sel_en_nx    = 1'b1;
            slot_tick_nx = 1'b1;
          end
        end
        ST_DRIVE: begin
          t_en      = 1'b1;
          sel_en_nx = 1'b1;
          if (t_zero) begin
            if ((sel == LAST_SLOT) && mode_q) begin
              state_nx  = ST_IDLE;
              sel_nx    = '0;
              sel_en_nx = 1'b0;
              done_nx   = 1'b1;
            end else begin
              sel_nx = (sel == LAST_SLOT) ? '0 : sel + SLOT_W'(1);
              t_load = 1'b1;
              if (BLANK > 0) begin
                state_nx  = ST_BLANK;
                t_val     = BLANK_LD;
                sel_en_nx = 1'b0;
              end else begin
                t_val        = DWELL_LD;
                slot_tick_nx = 1'b1;
              end
            end
          end
        end
        default: begin
          state_nx = ST_IDLE;
          sel_nx   = '0;
        end
      endcase
    end

    busy_nx = (state_nx != ST_IDLE);
  end

  assign bus.sel       = sel;
  assign bus.sel_en    = sel_en;
  assign bus.busy      = busy;
  assign bus.slot_tick = slot_tick;
  assign bus.done      = done;

endmodule
